// File: rtl/dest_reg_fwd_pipe.sv
// Destination-register select and DEPTH-stage dest/write-enable tracking with EX forwarding selects.
// Optional load-use hazard detection is enabled by defining FWD_LOAD_USE_DETECT_EN.
module dest_reg_fwd_pipe #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LINK_REG = 31,
  parameter int SEL_W    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [1:0]        dst_sel,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              stall,
  input  logic              flush,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
`ifdef FWD_LOAD_USE_DETECT_EN
  input  logic              id_is_load,
  input  logic [REG_AW-1:0] id_rs,
  output logic              hazard,
`endif
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b,
  output logic [REG_AW-1:0] ex_dst,
  output logic [REG_AW-1:0] wb_dst,
  output logic              wb_we
);

  localparam logic [REG_AW-1:0] LINK_DST = REG_AW'(LINK_REG);

  logic [REG_AW-1:0] dst_reg [DEPTH];
  logic              we_reg  [DEPTH];

  logic [REG_AW-1:0] sel_dst;
  logic              bubble;
  logic [REG_AW-1:0] dst0_next;
  logic              we0_next;

  // pick_x[k] is the select for the youngest matching stage at or above k
  logic [SEL_W-1:0]  pick_a [1:DEPTH];
  logic [SEL_W-1:0]  pick_b [1:DEPTH];

  always_comb begin
    sel_dst = '0;
    case (dst_sel)
      2'b00:   sel_dst = id_rd;
      2'b01:   sel_dst = id_rt;
      2'b10:   sel_dst = LINK_DST;
      default: sel_dst = '0;
    endcase
    bubble    = stall || flush || !id_valid;
    dst0_next = bubble ? '0 : sel_dst;
    we0_next  = !bubble && (dst_sel != 2'b11) && (sel_dst != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_reg[0] <= '0;
      we_reg[0]  <= 1'b0;
    end else begin
      dst_reg[0] <= dst0_next;
      we_reg[0]  <= we0_next;
    end
  end

  assign pick_a[DEPTH] = '0;
  assign pick_b[DEPTH] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_stage
      // Stage 1 is where a flushed EX instruction gets killed
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dst_reg[gi] <= '0;
          we_reg[gi]  <= 1'b0;
        end else if ((gi == 1) && flush) begin
          dst_reg[gi] <= '0;
          we_reg[gi]  <= 1'b0;
        end else begin
          dst_reg[gi] <= dst_reg[gi-1];
          we_reg[gi]  <= we_reg[gi-1];
        end
      end

      assign pick_a[gi] = (we_reg[gi] && (ex_rs != '0) && (dst_reg[gi] == ex_rs))
                          ? SEL_W'(gi) : pick_a[gi+1];
      assign pick_b[gi] = (we_reg[gi] && (ex_rt != '0) && (dst_reg[gi] == ex_rt))
                          ? SEL_W'(gi) : pick_b[gi+1];
    end
  endgenerate

  assign fwd_a  = pick_a[1];
  assign fwd_b  = pick_b[1];
  assign ex_dst = dst_reg[0];
  assign wb_dst = dst_reg[DEPTH-1];
  assign wb_we  = we_reg[DEPTH-1];

`ifdef FWD_LOAD_USE_DETECT_EN
  logic ld_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_reg <= 1'b0;
    end else begin
      ld_reg <= !bubble && id_is_load;
    end
  end

  // A load in EX whose result the ID instruction needs cannot be forwarded in time
  assign hazard = ld_reg && we_reg[0] && (dst_reg[0] != '0) &&
                  ((dst_reg[0] == id_rs) || (dst_reg[0] == id_rt));
`endif

endmodule

// File: tb/tb_dest_reg_fwd_pipe.sv
// Directed table-driven bench for dest_reg_fwd_pipe (DEPTH=3, LINK_REG=31),
// plus hand-written reset and (with FWD_LOAD_USE_DETECT_EN) hazard sequences.
module tb_dest_reg_fwd_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [1:0] dst_sel = 2'b00;
  logic [4:0] id_rt = '0;
  logic [4:0] id_rd = '0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic [4:0] ex_rs = '0;
  logic [4:0] ex_rt = '0;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic [4:0] ex_dst;
  logic [4:0] wb_dst;
  logic       wb_we;
`ifdef FWD_LOAD_USE_DETECT_EN
  logic       id_is_load = 1'b0;
  logic [4:0] id_rs = '0;
  logic       hazard;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dest_reg_fwd_pipe #(.REG_AW(5), .DEPTH(3), .LINK_REG(31), .SEL_W(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_valid(id_valid),
    .dst_sel(dst_sel),
    .id_rt(id_rt),
    .id_rd(id_rd),
    .stall(stall),
    .flush(flush),
    .ex_rs(ex_rs),
    .ex_rt(ex_rt),
`ifdef FWD_LOAD_USE_DETECT_EN
    .id_is_load(id_is_load),
    .id_rs(id_rs),
    .hazard(hazard),
`endif
    .fwd_a(fwd_a),
    .fwd_b(fwd_b),
    .ex_dst(ex_dst),
    .wb_dst(wb_dst),
    .wb_we(wb_we)
  );

  typedef struct {
    logic       iv;
    logic [1:0] sel;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       st;
    logic       fl;
    logic [4:0] rs;
    logic [4:0] ert;
    logic       chk_ex;
    logic       chk_wb;
    logic [4:0] e_ex;
    logic [4:0] e_wb;
    logic       e_we;
    logic [1:0] e_fa;
    logic [1:0] e_fb;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(input int iv, input int sel, input int rt, input int rd,
                              input int st, input int fl, input int rs, input int ert,
                              input int chk_ex, input int chk_wb, input int e_ex,
                              input int e_wb, input int e_we, input int e_fa, input int e_fb);
    vec_t v;
    v.iv = iv[0];     v.sel = sel[1:0]; v.rt = rt[4:0];   v.rd = rd[4:0];
    v.st = st[0];     v.fl = fl[0];     v.rs = rs[4:0];   v.ert = ert[4:0];
    v.chk_ex = chk_ex[0]; v.chk_wb = chk_wb[0];
    v.e_ex = e_ex[4:0]; v.e_wb = e_wb[4:0]; v.e_we = e_we[0];
    v.e_fa = e_fa[1:0]; v.e_fb = e_fb[1:0];
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int sel, input int rd);
    id_valid = 1'b1;
    dst_sel  = sel[1:0];
    id_rd    = rd[4:0];
    step();
  endtask

  initial begin
    //            iv sel rt rd st fl rs ert cex cwb ex  wb we fa fb
    vecs[0]  = mk(1, 0, 0, 7, 0, 0, 0, 0,   1, 1,  7,  0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 9, 3, 0, 0, 7, 9,   1, 1,  9,  0, 0, 1, 0);
    vecs[2]  = mk(1, 2, 0, 0, 0, 0, 7, 9,   1, 1, 31,  7, 1, 2, 1);
    vecs[3]  = mk(1, 0, 0, 0, 0, 0, 31, 9,  1, 1,  0,  9, 1, 1, 2);
    vecs[4]  = mk(1, 3, 5, 5, 0, 0, 0, 31,  0, 1,  0, 31, 1, 0, 2);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 5, 0,   1, 1,  0,  0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 5, 0,   1, 0,  0,  0, 0, 0, 0);
    vecs[7]  = mk(1, 0, 0, 4, 0, 0, 0, 0,   1, 1,  4,  0, 0, 0, 0);
    vecs[8]  = mk(1, 0, 0, 4, 0, 0, 0, 0,   1, 1,  4,  0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 4, 0,   1, 1,  0,  4, 1, 1, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 4, 4,   1, 1,  0,  4, 1, 2, 2);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 4, 4,   1, 1,  0,  0, 0, 0, 0);
    vecs[12] = mk(1, 0, 0, 10, 0, 0, 0, 0,  1, 1, 10,  0, 0, 0, 0);
    vecs[13] = mk(1, 0, 0, 6, 1, 0, 10, 6,  1, 1,  0,  0, 0, 1, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 10, 6,  1, 1,  0, 10, 1, 2, 0);
    vecs[15] = mk(1, 0, 0, 8, 0, 0, 0, 0,   1, 1,  8,  0, 0, 0, 0);
    vecs[16] = mk(1, 0, 0, 12, 0, 1, 8, 0,  1, 1,  0,  0, 0, 0, 0);
    vecs[17] = mk(1, 0, 0, 13, 1, 1, 8, 0,  1, 1,  0,  0, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 8, 0,   1, 1,  0,  0, 0, 0, 0);
    vecs[19] = mk(1, 0, 0, 14, 0, 0, 0, 0,  1, 1, 14,  0, 0, 0, 0);
    vecs[20] = mk(1, 0, 0, 15, 0, 0, 14, 0, 1, 1, 15,  0, 0, 1, 0);
    vecs[21] = mk(0, 0, 0, 0, 0, 1, 14, 15, 1, 1,  0, 14, 1, 2, 0);
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 14, 15, 1, 1,  0,  0, 0, 0, 0);

    // Reset state while rst_n is low
    #1;
    chk("rst_ex_dst", ex_dst, 0);
    chk("rst_wb_dst", wb_dst, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_fwd_b", fwd_b, 0);
`ifdef FWD_LOAD_USE_DETECT_EN
    chk("rst_hazard", hazard, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      id_valid = vecs[i].iv;
      dst_sel  = vecs[i].sel;
      id_rt    = vecs[i].rt;
      id_rd    = vecs[i].rd;
      stall    = vecs[i].st;
      flush    = vecs[i].fl;
      ex_rs    = vecs[i].rs;
      ex_rt    = vecs[i].ert;
      step();
      $display("vec %0d: ex_dst=%0d wb_dst=%0d wb_we=%0d fwd_a=%0d fwd_b=%0d",
               i, ex_dst, wb_dst, wb_we, fwd_a, fwd_b);
      if (vecs[i].chk_ex) chk($sformatf("v%0d_ex_dst", i), ex_dst, vecs[i].e_ex);
      if (vecs[i].chk_wb) chk($sformatf("v%0d_wb_dst", i), wb_dst, vecs[i].e_wb);
      chk($sformatf("v%0d_wb_we", i), wb_we, vecs[i].e_we);
      chk($sformatf("v%0d_fwd_a", i), fwd_a, vecs[i].e_fa);
      chk($sformatf("v%0d_fwd_b", i), fwd_b, vecs[i].e_fb);
    end
    stall = 1'b0;
    flush = 1'b0;
    ex_rt = '0;

    // Mid-stream asynchronous reset, then latency of the first post-reset entry
    issue(0, 21);
    issue(0, 22);
    issue(0, 23);
    ex_rs = 5'd22;
    #1;
    $display("pre-reset: wb_dst=%0d wb_we=%0d fwd_a=%0d", wb_dst, wb_we, fwd_a);
    chk("pre_rst_wb_we", wb_we, 1);
    chk("pre_rst_fwd_a", fwd_a, 1);
    rst_n = 1'b0;
    #2;
    $display("async reset: ex_dst=%0d wb_dst=%0d wb_we=%0d fwd_a=%0d", ex_dst, wb_dst, wb_we, fwd_a);
    chk("mid_rst_ex_dst", ex_dst, 0);
    chk("mid_rst_wb_dst", wb_dst, 0);
    chk("mid_rst_wb_we", wb_we, 0);
    chk("mid_rst_fwd_a", fwd_a, 0);
    step();
    chk("held_rst_wb_we", wb_we, 0);
    @(negedge clk);
    ex_rs    = '0;
    id_valid = 1'b1;
    dst_sel  = 2'b00;
    id_rd    = 5'd20;
    rst_n    = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      $display("post-reset edge %0d: ex_dst=%0d wb_dst=%0d wb_we=%0d", e, ex_dst, wb_dst, wb_we);
      chk($sformatf("post_rst_e%0d_wb_we", e), wb_we, (e == 3) ? 1 : 0);
      if (e == 1) chk("post_rst_e1_ex_dst", ex_dst, 20);
      if (e == 3) chk("post_rst_e3_wb_dst", wb_dst, 20);
    end

`ifdef FWD_LOAD_USE_DETECT_EN
    // Load-use detection against the instruction sitting in ID
    id_is_load = 1'b1;
    issue(0, 3);
    id_is_load = 1'b0;
    id_valid   = 1'b0;
    id_rs = 5'd3; id_rt = 5'd0;
    #1;
    $display("hazard load r3, id_rs=3: hazard=%0d", hazard);
    chk("hz_rs_match", hazard, 1);
    id_rs = 5'd2; id_rt = 5'd2;
    #1;
    $display("hazard load r3, id_rs=id_rt=2: hazard=%0d", hazard);
    chk("hz_no_match", hazard, 0);
    id_rs = 5'd0; id_rt = 5'd3;
    #1;
    $display("hazard load r3, id_rt=3: hazard=%0d", hazard);
    chk("hz_rt_match", hazard, 1);
    issue(0, 3);
    id_valid = 1'b0;
    id_rs = 5'd3; id_rt = 5'd0;
    #1;
    $display("hazard non-load r3, id_rs=3: hazard=%0d", hazard);
    chk("hz_nonload", hazard, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
